// File: rtl/rf_arb_pkg.sv
// Shared types and sizes for the pico register-file arbiter.
package pico;
  localparam int N    = 16;
  localparam int R    = 8;
  localparam int NREQ = 2;
  localparam int AW   = $clog2(R);

  typedef struct packed {
    logic                 we;
    logic [AW-1:0]        rs_addr;
    logic [AW-1:0]        rd_addr;
    logic signed [N-1:0]  wdata;
  } rf_req_t;
endpackage

// File: rtl/rf_arb_if.sv
// Requester and register-file side signals of rf_arb, bundled into one interface.
interface rf_arb_if;
  import pico::*;

  logic [NREQ-1:0]          req_valid_i;
  rf_req_t [NREQ-1:0]       req_i;
  logic [NREQ-1:0]          req_ready_o;
  logic [NREQ-1:0]          rsp_valid_o;
  logic signed [N-1:0]      rsp_rs_data_o;
  logic signed [N-1:0]      rsp_rd_data_o;
  logic                     rf_wr_en_o;
  logic signed [N-1:0]      rf_wd_data_o;
  logic [AW-1:0]            rf_rs_addr_o;
  logic [AW-1:0]            rf_rd_addr_o;
  logic signed [N-1:0]      rf_rs_data_i;
  logic signed [N-1:0]      rf_rd_data_i;

  modport slave (
    input  req_valid_i, req_i, rf_rs_data_i, rf_rd_data_i,
    output req_ready_o, rsp_valid_o, rsp_rs_data_o, rsp_rd_data_o,
           rf_wr_en_o, rf_wd_data_o, rf_rs_addr_o, rf_rd_addr_o
  );

  modport master (
    output req_valid_i, req_i, rf_rs_data_i, rf_rd_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rs_data_o, rsp_rd_data_o,
           rf_wr_en_o, rf_wd_data_o, rf_rs_addr_o, rf_rd_addr_o
  );
endinterface

// File: rtl/rf_arb_rr_arb2.sv
// Two-way grant generator: round-robin by default, fixed priority with
// starvation relief for requester 1 when RF_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

  if (STARVE_MAX < 1) begin : g_starve_chk
    $error("STARVE_MAX must be at least 1");
  end

`ifdef RF_ARB_FIXED_PRIO_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve;

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (valid[1] && (!valid[0] || starve == CW'(STARVE_MAX)))
        gnt = 2'b10;
      else if (valid[0])
        gnt = 2'b01;
    end
  end

  // Counts lost cycles of requester 1, saturating at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (!rst_n)
      starve <= '0;
    else if (!valid[1] || gnt[1])
      starve <= '0;
    else if (starve != CW'(STARVE_MAX))
      starve <= starve + 1'b1;
  end
`else
  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (valid == 2'b11)
        gnt = last_gnt ? 2'b01 : 2'b10;
      else
        gnt = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_gnt <= 1'b1;
    else if (|(valid & gnt))
      last_gnt <= gnt[1];
  end
`endif

endmodule

// File: rtl/rf_arb.sv
// Shares the pico register file between two requesters; grant policy is
// selected by RF_ARB_FIXED_PRIO_EN (undefined: round-robin).
module rf_arb
  import pico::*;
#(
  parameter int N          = pico::N,
  parameter int R          = pico::R,
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  rf_arb_if.slave bus
);

  localparam int AW_L = $clog2(R);

  logic [1:0]          gnt;
  logic                any_gnt;
  rf_req_t             win;
  logic [1:0]          rsp_valid_q;
  logic signed [N-1:0] rs_q;
  logic signed [N-1:0] rd_q;

  rr_arb2 #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .valid (bus.req_valid_i),
    .gnt   (gnt)
  );

  // gnt is already qualified by valid, so a grant bit means an accepted transfer.
  always_comb begin
    any_gnt = |gnt;
    win     = '0;
    if (gnt[1])
      win = bus.req_i[1];
    else if (gnt[0])
      win = bus.req_i[0];
  end

  assign bus.req_ready_o  = gnt;
  assign bus.rf_wr_en_o   = any_gnt & win.we;
  assign bus.rf_wd_data_o = N'(win.wdata);
  assign bus.rf_rs_addr_o = AW_L'(win.rs_addr);
  assign bus.rf_rd_addr_o = AW_L'(win.rd_addr);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 2'b00;
      rs_q        <= '0;
      rd_q        <= '0;
    end else begin
      rsp_valid_q <= gnt;
      if (any_gnt) begin
        rs_q <= bus.rf_rs_data_i;
        rd_q <= bus.rf_rd_data_i;
      end
    end
  end

  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rs_data_o = rs_q;
  assign bus.rsp_rd_data_o = rd_q;

endmodule

// File: tb/tb_rf_arb.sv
// Scoreboard bench for rf_arb with a behavioural register file behind it.
module tb_rf_arb;
  import pico::*;

  typedef struct {
    logic [1:0]          who;
    logic signed [N-1:0] rs;
    logic signed [N-1:0] rd;
    int                  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rf_arb_if bus ();

  rf_arb #(.N(N), .R(R), .STARVE_MAX(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Register file: combinational reads, r0 hardwired to zero, write at the edge.
  logic signed [N-1:0] mem [R] = '{default: '0};
  assign bus.rf_rs_data_i = (bus.rf_rs_addr_o == '0) ? '0 : mem[bus.rf_rs_addr_o];
  assign bus.rf_rd_data_i = (bus.rf_rd_addr_o == '0) ? '0 : mem[bus.rf_rd_addr_o];
  always @(posedge clk)
    if (bus.rf_wr_en_o && bus.rf_rd_addr_o != '0)
      mem[bus.rf_rd_addr_o] <= bus.rf_wd_data_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic signed [N-1:0] rs, input logic signed [N-1:0] rd);
    exp_t e;
    e.who = who; e.rs = rs; e.rd = rd; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per response strobe.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_missing: got none expected who=%0b at cycle %0d", q[0].who, q[0].cyc);
      void'(q.pop_front());
    end
    if (bus.rsp_valid_o != 2'b00) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=%0b expected 0 (cycle %0d)", bus.rsp_valid_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_who", 64'(bus.rsp_valid_o), 64'(e.who));
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        check("rsp_rs_data", 64'(bus.rsp_rs_data_o), 64'(e.rs));
        check("rsp_rd_data", 64'(bus.rsp_rd_data_o), 64'(e.rd));
      end
    end
  end

  // One transfer from a lone requester; called at a falling edge.
  task automatic xfer(input int r, input logic we, input logic [AW-1:0] rs, input logic [AW-1:0] rd,
                      input logic signed [N-1:0] wd, input logic signed [N-1:0] exp_rs,
                      input logic signed [N-1:0] exp_rd);
    logic [1:0] onehot;
    onehot = 2'b01 << r;
    bus.req_valid_i = onehot;
    bus.req_i[r] = '{we: we, rs_addr: rs, rd_addr: rd, wdata: wd};
    #1;
    check("grant_single", 64'(bus.req_ready_o), 64'(onehot));
    check("rf_wr_en", 64'(bus.rf_wr_en_o), 64'(we));
    check("rf_rs_addr", 64'(bus.rf_rs_addr_o), 64'(rs));
    check("rf_rd_addr", 64'(bus.rf_rd_addr_o), 64'(rd));
    check("rf_wd_data", 64'(bus.rf_wd_data_o), 64'(wd));
    if (bus.req_ready_o == onehot) push(onehot, exp_rs, exp_rd);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ncyc;
    int w;
    bus.req_valid_i = 2'b00;
    bus.req_i = '0;

    // Reset: no grant even with both requesters valid.
    @(negedge clk);
    bus.req_valid_i = 2'b11;
    #1;
    check("rst_ready", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_rs_data", 64'(bus.rsp_rs_data_o), 64'd0);
    check("rst_rd_data", 64'(bus.rsp_rd_data_o), 64'd0);
    rst_n = 1'b1;

    // r3 = 0x5A, then read back.
    xfer(0, 1'b1, 3'd0, 3'd3, 16'sh5A, 16'sh0, 16'sh0);
    xfer(0, 1'b0, 3'd3, 3'd3, 16'sh0, 16'sh5A, 16'sh5A);

    // Fresh reset so requester 0 wins the first contention.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RF_ARB_FIXED_PRIO_EN
    ncyc = 10;
`else
    ncyc = 6;
`endif
    bus.req_i[0] = '{we: 1'b0, rs_addr: 3'd0, rd_addr: 3'd3, wdata: 16'sh0};
    bus.req_i[1] = '{we: 1'b0, rs_addr: 3'd3, rd_addr: 3'd0, wdata: 16'sh0};
    for (int i = 0; i < ncyc; i++) begin
      bus.req_valid_i = 2'b11;
      #1;
`ifdef RF_ARB_FIXED_PRIO_EN
      w = (i % 5 == 4) ? 1 : 0;
`else
      w = i % 2;
`endif
      check("grant_contend", 64'(bus.req_ready_o), 64'(2'b01 << w));
      if (w == 0) push(2'b01, 16'sh0, 16'sh5A);
      else        push(2'b10, 16'sh5A, 16'sh0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid_i = 2'b00;

    // Write to r0 is discarded by the register file.
    xfer(0, 1'b1, 3'd0, 3'd0, 16'sh7F, 16'sh0, 16'sh0);
    xfer(0, 1'b0, 3'd0, 3'd0, 16'sh0, 16'sh0, 16'sh0);

    // Read-during-write returns the old value.
    xfer(1, 1'b1, 3'd0, 3'd5, 16'sh22, 16'sh0, 16'sh0);
    xfer(1, 1'b1, 3'd5, 3'd5, 16'sh11, 16'sh22, 16'sh22);
    xfer(1, 1'b0, 3'd5, 3'd5, 16'sh0, 16'sh11, 16'sh11);

    // Reset in the cycle requester 1 would write r2.
    bus.req_valid_i = 2'b10;
    bus.req_i[1] = '{we: 1'b1, rs_addr: 3'd0, rd_addr: 3'd2, wdata: 16'sh33};
    rst_n = 1'b0;
    #1;
    check("rst_wr_ready", 64'(bus.req_ready_o), 64'd0);
    check("rst_wr_en", 64'(bus.rf_wr_en_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    rst_n = 1'b1;
    xfer(0, 1'b0, 3'd2, 3'd2, 16'sh0, 16'sh0, 16'sh0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
